// File: rtl/stop_watch_btn_ctrl_amisha.sv
`default_nettype none
// ============================================================================
//  Module   : stop_watch_btn_ctrl_amisha
//  Purpose  : Button conditioning for the stopwatch. Each button gets a 2-FF
//             synchroniser, a debounce FSM and press-edge detection. btn[1]
//             toggles go, btn[0] pulses clr.
//  Option   : STOPWATCH_CLR_STOPS_EN - a clear press also forces go to 0
//  Revision : 1.0 - initial release
// ============================================================================
module stop_watch_btn_ctrl_amisha #(
   parameter int N = 19
) (
   input  logic       clk_amisha,
   input  logic       reset_amisha,
   input  logic [1:0] btn_amisha,
   output logic       go_amisha,
   output logic       clr_amisha,
   output logic [1:0] db_amisha
);

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } db_state_t;

   localparam logic [N-1:0] C_RELOAD = '1;

   logic [1:0] r_s1;
   logic [1:0] r_s2;
   logic [1:0] w_tick;
   logic [1:0] w_db;
   logic       r_go;
   logic       r_clr;

   always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
         r_s1 <= 2'b00;
         r_s2 <= 2'b00;
      end else begin
         r_s1 <= btn_amisha;
         r_s2 <= r_s1;
      end
   end

   // One debounce FSM per button; tick fires only on the settle into ONE.
   for (genvar i = 0; i < 2; i++) begin : g_btn
      db_state_t    r_state;
      db_state_t    w_state_next;
      logic [N-1:0] r_cnt;
      logic [N-1:0] w_cnt_next;
      logic         r_tick;
      logic         w_tick_next;

      always_ff @(posedge clk_amisha or posedge reset_amisha) begin
         if (reset_amisha) begin
            r_state <= ZERO;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
         end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_tick  <= w_tick_next;
         end
      end

      always_comb begin
         w_state_next = r_state;
         w_cnt_next   = r_cnt;
         w_tick_next  = 1'b0;
         case (r_state)
            ZERO: begin
               if (r_s2[i]) begin
                  w_state_next = WAIT1;
                  w_cnt_next   = C_RELOAD;
               end
            end
            WAIT1: begin
               if (!r_s2[i]) begin
                  w_state_next = ZERO;
               end else if (r_cnt != '0) begin
                  w_cnt_next = r_cnt - 1'b1;
               end else begin
                  w_state_next = ONE;
                  w_tick_next  = 1'b1;
               end
            end
            ONE: begin
               if (!r_s2[i]) begin
                  w_state_next = WAIT0;
                  w_cnt_next   = C_RELOAD;
               end
            end
            WAIT0: begin
               if (r_s2[i]) begin
                  w_state_next = ONE;
               end else if (r_cnt != '0) begin
                  w_cnt_next = r_cnt - 1'b1;
               end else begin
                  w_state_next = ZERO;
               end
            end
            default: begin
               w_state_next = ZERO;
            end
         endcase
      end

      assign w_tick[i] = r_tick;
      assign w_db[i]   = (r_state == ONE) || (r_state == WAIT0);
   end

   always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
         r_go  <= 1'b0;
         r_clr <= 1'b0;
      end else begin
         r_clr <= w_tick[0];
`ifdef STOPWATCH_CLR_STOPS_EN
         // Clear has priority so a simultaneous press always leaves go stopped.
         if (w_tick[0]) begin
            r_go <= 1'b0;
         end else if (w_tick[1]) begin
            r_go <= ~r_go;
         end
`else
         if (w_tick[1]) begin
            r_go <= ~r_go;
         end
`endif
      end
   end

   assign go_amisha  = r_go;
   assign clr_amisha = r_clr;
   assign db_amisha  = w_db;

endmodule
`default_nettype wire

// File: tb/tb_stop_watch_btn_ctrl_amisha.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stop_watch_btn_ctrl_amisha
//  Purpose  : Directed bench for the button controller (N=4). A run-length
//             model predicts go/clr/db every cycle; literal checks pin timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stop_watch_btn_ctrl_amisha;

   localparam int N      = 4;
   localparam int STABLE = (2 ** N) + 1;  // consecutive synced samples needed to flip
   localparam int DB_LAT = (2 ** N) + 2;  // first sampling edge -> db change
   localparam int OUT_LAT = DB_LAT + 1;   // first sampling edge -> go/clr change

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] btn = 2'b11;
   logic       go;
   logic       clr;
   logic [1:0] db;

   stop_watch_btn_ctrl_amisha #(.N(N)) dut (
      .clk_amisha   (clk),
      .reset_amisha (rst),
      .btn_amisha   (btn),
      .go_amisha    (go),
      .clr_amisha   (clr),
      .db_amisha    (db)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural model: a level flips once the synchronised input has
   // disagreed with it for STABLE consecutive samples.
   logic [1:0] m_s1, m_s2, m_db, m_tick;
   logic       m_go, m_clr;
   int         m_run [2];

   always @(posedge clk or posedge rst) begin
      logic [1:0] nt;
      logic [1:0] ndb;
      logic       ngo;
      int         nrun [2];
      if (rst) begin
         m_s1 <= 2'b00; m_s2 <= 2'b00; m_db <= 2'b00; m_tick <= 2'b00;
         m_go <= 1'b0;  m_clr <= 1'b0;
         m_run[0] <= 0; m_run[1] <= 0;
      end else begin
         ngo = m_go;
`ifdef STOPWATCH_CLR_STOPS_EN
         if (m_tick[0]) ngo = 1'b0;
         else if (m_tick[1]) ngo = ~m_go;
`else
         if (m_tick[1]) ngo = ~m_go;
`endif
         nt  = 2'b00;
         ndb = m_db;
         for (int b = 0; b < 2; b++) begin
            nrun[b] = m_run[b];
            if (m_s2[b] == m_db[b]) begin
               nrun[b] = 0;
            end else begin
               nrun[b] = m_run[b] + 1;
               if (nrun[b] == STABLE) begin
                  ndb[b]  = m_s2[b];
                  nrun[b] = 0;
                  nt[b]   = m_s2[b];
               end
            end
         end
         m_clr    <= m_tick[0];
         m_go     <= ngo;
         m_db     <= ndb;
         m_tick   <= nt;
         m_run[0] <= nrun[0];
         m_run[1] <= nrun[1];
         m_s2     <= m_s1;
         m_s1     <= btn;
      end
   end

   // Per-cycle compare plus event bookkeeping used by the literal checks.
   int   n_vec = 0, n_err = 0;
   int   clr_cnt = 0, go_tog = 0;
   int   last_clr_cyc = -1, last_go_cyc = -1;
   int   db1_rise = -1, db1_fall = -1;
   logic prev_go = 1'b0, prev_db1 = 1'b0;

   always @(negedge clk) begin
      n_vec++;
      if (go !== m_go || clr !== m_clr || db !== m_db) begin
         n_err++;
         $display("FAIL cycle_compare cyc=%0d actual go=%b clr=%b db=%b required go=%b clr=%b db=%b",
                  cyc, go, clr, db, m_go, m_clr, m_db);
      end
      if (clr === 1'b1) begin
         clr_cnt++;
         last_clr_cyc = cyc;
      end
      if (go !== prev_go) begin
         go_tog++;
         last_go_cyc = cyc;
      end
      if (db[1] === 1'b1 && !prev_db1) db1_rise = cyc;
      if (db[1] === 1'b0 && prev_db1)  db1_fall = cyc;
      prev_go  = go;
      prev_db1 = db[1];
   end

   int n_lit = 0, n_litfail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_lit++;
      if (act != exp) begin
         n_litfail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      btn = 2'b00;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(3);
   endtask

   task automatic clean_press(input logic [1:0] b);
      btn = b;
      step(25);
      btn = 2'b00;
      step(25);
   endtask

   initial begin
      int e0, er, c0, g0;
      // reset state, buttons already held
      step(3);
      chk("reset_go", go, 0);
      chk("reset_clr", clr, 0);
      chk("reset_db", db, 0);

      // 1: held through reset release -> one go toggle, one clr pulse
      c0 = clr_cnt; g0 = go_tog;
      rst = 1'b0;
      e0 = cyc + 1;
      step(40);
      chk("t1_clr_count", clr_cnt - c0, 1);
      chk("t1_clr_edge", last_clr_cyc, e0 + OUT_LAT);
      chk("t1_go_toggles", go_tog - g0, 1);
      chk("t1_go_edge", last_go_cyc, e0 + OUT_LAT);
      chk("t1_go", go, 1);
      chk("t1_db", db, 3);
      btn = 2'b00;
      step(30);
      chk("t1_db_released", db, 0);
      chk("t1_release_no_pulse", clr_cnt - c0, 1);

      // 2: bounce on btn[1], then stable hold
      do_reset();
      g0 = go_tog;
      for (int k = 0; k < 40; k++) begin
         btn[1] = ((k / 3) % 2 == 0);
         step(1);
      end
      chk("t2_no_tick_bounce", go_tog - g0, 0);
      btn[1] = 1'b1;
      e0 = cyc + 1;
      step(30);
      chk("t2_toggles", go_tog - g0, 1);
      chk("t2_go_edge", last_go_cyc, e0 + OUT_LAT);
      chk("t2_go", go, 1);
      btn = 2'b00;
      step(25);

      // 3: two clean presses on btn[1]
      do_reset();
      g0 = go_tog;
      for (int p = 0; p < 2; p++) begin
         btn[1] = 1'b1;
         e0 = cyc + 1;
         step(25);
         chk("t3_db1_rise", db1_rise, e0 + DB_LAT);
         chk("t3_go_after_press", go, (p == 0) ? 1 : 0);
         btn[1] = 1'b0;
         er = cyc + 1;
         step(25);
         chk("t3_db1_fall", db1_fall, er + DB_LAT);
      end
      chk("t3_toggles", go_tog - g0, 2);

      // 4: long clear hold -> single pulse
      do_reset();
      c0 = clr_cnt; g0 = go_tog;
      btn = 2'b01;
      step(100);
      chk("t4_clr_count", clr_cnt - c0, 1);
      chk("t4_go_unchanged", go_tog - g0, 0);
      btn = 2'b00;
      step(25);

      // 5: simultaneous presses
      do_reset();
      clean_press(2'b10);
      chk("t5_go_set", go, 1);
      c0 = clr_cnt;
      clean_press(2'b11);
      chk("t5_clr_pulse", clr_cnt - c0, 1);
      chk("t5_go_from1", go, 0);
      clean_press(2'b11);
      chk("t5_clr_pulse2", clr_cnt - c0, 2);
`ifdef STOPWATCH_CLR_STOPS_EN
      chk("t5_go_from0", go, 0);
`else
      chk("t5_go_from0", go, 1);
`endif

      // 6: asynchronous reset in the middle of a WAIT1 window
      do_reset();
      clean_press(2'b10);
      chk("t6_go_set", go, 1);
      btn = 2'b10;
      step(10);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_go", go, 0);
      chk("t6_async_clr", clr, 0);
      chk("t6_async_db", db, 0);
      step(2);
      g0 = go_tog;
      rst = 1'b0;
      e0 = cyc + 1;
      step(30);
      chk("t6_one_tick", go_tog - g0, 1);
      chk("t6_go_edge", last_go_cyc, e0 + OUT_LAT);
      chk("t6_go", go, 1);
      btn = 2'b00;
      step(25);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec + n_lit, n_err + n_litfail);
      $finish;
   end

endmodule
`default_nettype wire
